// File: rtl/wb_arb_defs.sv
// Shared definitions for the main-RAM Wishbone arbiter: CTI codes and the arbiter state encoding.
package wb_arb_defs;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Bundle of the per-master request/response buses and the shared RAM slave port.
interface wb_mem_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
    logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
    logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i;
    logic [NUM_MASTERS-1:0]        wbm_we_i;
    logic [NUM_MASTERS-1:0]        wbm_cyc_i;
    logic [NUM_MASTERS-1:0]        wbm_stb_i;
    logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
    logic [NUM_MASTERS*DW-1:0]     wbm_dat_o;
    logic [NUM_MASTERS-1:0]        wbm_ack_o;
    logic [NUM_MASTERS-1:0]        wbm_err_o;
    logic [NUM_MASTERS-1:0]        wbm_rty_o;

    logic [AW-1:0]                 wbs_adr_o;
    logic [DW-1:0]                 wbs_dat_o;
    logic [DW/8-1:0]               wbs_sel_o;
    logic                          wbs_we_o;
    logic                          wbs_cyc_o;
    logic                          wbs_stb_o;
    logic [2:0]                    wbs_cti_o;
    logic [1:0]                    wbs_bte_o;
    logic [DW-1:0]                 wbs_dat_i;
    logic                          wbs_ack_i;
    logic                          wbs_err_i;
    logic                          wbs_rty_i;

    // Arbiter view: slave to the cores, master towards the RAM.
    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping around.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  last,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  idx
);

    logic found;

    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise the
        // paths that find no requester would infer latches.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (int'(last) + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = ($clog2(N))'(k);
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter for the shared main-RAM port, with per-request watchdog and write snoop.
module wb_mem_arbiter
    import wb_arb_defs::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_mem_arbiter_if.slave        bus,
    output logic [AW-1:0]          snoop_adr_o,
    output logic                   snoop_en_o,
    output logic [NUM_MASTERS-1:0] grant_o
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e             state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt, pick_gnt;
    logic [IW-1:0]          gidx, gidx_nxt, last, last_nxt, pick_idx;
    logic [WW-1:0]          wdog, wdog_nxt;
    logic                   timed_out, timed_out_nxt;
    logic                   busy, cyc_g, stb_g, resp, timeout_now, active;

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req  (bus.wbm_cyc_i),
        .last (last),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    assign busy  = (state == BUSY);
    assign cyc_g = bus.wbm_cyc_i[gidx];
    assign stb_g = bus.wbm_stb_i[gidx];
    assign resp  = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

    // A response landing on the expiry cycle wins over the forced error.
    assign timeout_now = (TIMEOUT != 0) && busy && cyc_g && stb_g && !timed_out && !resp
                         && (wdog == WW'(TIMEOUT - 1));
    assign active      = busy && cyc_g && !timed_out && !timeout_now;

    assign bus.wbs_adr_o = busy ? bus.wbm_adr_i[gidx*AW +: AW] : '0;
    assign bus.wbs_dat_o = busy ? bus.wbm_dat_i[gidx*DW +: DW] : '0;
    assign bus.wbs_sel_o = busy ? bus.wbm_sel_i[gidx*SW +: SW] : '0;
    assign bus.wbs_cti_o = busy ? bus.wbm_cti_i[gidx*3 +: 3]   : '0;
    assign bus.wbs_bte_o = busy ? bus.wbm_bte_i[gidx*2 +: 2]   : '0;
    assign bus.wbs_we_o  = busy && bus.wbm_we_i[gidx];
    assign bus.wbs_cyc_o = active;
    assign bus.wbs_stb_o = active && stb_g;

    assign bus.wbm_dat_o = {NUM_MASTERS{bus.wbs_dat_i}};
    assign bus.wbm_ack_o = (active && bus.wbs_ack_i) ? grant : '0;
    assign bus.wbm_err_o = ((active && bus.wbs_err_i) || timeout_now) ? grant : '0;
    assign bus.wbm_rty_o = (active && bus.wbs_rty_i) ? grant : '0;
    assign grant_o       = grant;

    assign snoop_en_o  = bus.wbs_cyc_o && bus.wbs_stb_o && bus.wbs_we_o && bus.wbs_ack_i;
    assign snoop_adr_o = bus.wbs_adr_o;

    always_ff @(posedge wb_clk_i) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            state     <= IDLE;
            grant     <= '0;
            gidx      <= '0;
            last      <= IW'(NUM_MASTERS - 1);
            wdog      <= '0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            gidx      <= gidx_nxt;
            last      <= last_nxt;
            wdog      <= wdog_nxt;
            timed_out <= timed_out_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        gidx_nxt      = gidx;
        last_nxt      = last;
        wdog_nxt      = wdog;
        timed_out_nxt = timed_out;
        case (state)
            IDLE: begin
                if (|bus.wbm_cyc_i) begin
                    state_nxt     = BUSY;
                    grant_nxt     = pick_gnt;
                    gidx_nxt      = pick_idx;
                    last_nxt      = pick_idx;
                    wdog_nxt      = '0;
                    timed_out_nxt = 1'b0;
                end
            end
            BUSY: begin
                // Grant is held for as long as the owner keeps cyc high.
                if (!cyc_g) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    wdog_nxt      = '0;
                    timed_out_nxt = 1'b0;
                end else if (timeout_now) begin
                    timed_out_nxt = 1'b1;
                    wdog_nxt      = '0;
                end else if (!stb_g || resp) begin
                    wdog_nxt = '0;
                end else if (!timed_out) begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: vector table for classic/snoop cycles plus rotation, burst, watchdog and reset sequences.
module tb_wb_mem_arbiter;
    import wb_arb_defs::*;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mute = 1'b0;
    logic [AW-1:0] snoop_adr;
    logic          snoop_en;
    logic [NM-1:0] grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter_if #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) bus ();

    wb_mem_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .bus         (bus),
        .snoop_adr_o (snoop_adr),
        .snoop_en_o  (snoop_en),
        .grant_o     (grant)
    );

    // RAM model: one wait state, ack on the second stb cycle, data = address ^ 0x5A5A5A5A.
    always @(posedge clk) begin
        if (rst) begin
            bus.wbs_ack_i <= 1'b0;
            bus.wbs_dat_i <= '0;
        end else begin
            bus.wbs_ack_i <= !mute && bus.wbs_cyc_o && bus.wbs_stb_o && !bus.wbs_ack_i;
            bus.wbs_dat_i <= bus.wbs_adr_o ^ 32'h5A5A_5A5A;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not end by 400000");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  cyc;
        logic [3:0]  stb;
        logic [3:0]  we;
        logic [3:0]  exp_grant;
        logic        exp_scyc;
        logic [31:0] exp_sadr;
        logic [3:0]  exp_ack;
        logic        exp_snoop;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int k, input logic [31:0] adr, input logic [31:0] dat,
                              input logic we, input logic [2:0] cti);
        bus.wbm_adr_i[k*AW +: AW] = adr;
        bus.wbm_dat_i[k*DW +: DW] = dat;
        bus.wbm_sel_i[k*4 +: 4]   = 4'hF;
        bus.wbm_we_i[k]           = we;
        bus.wbm_cti_i[k*3 +: 3]   = cti;
        bus.wbm_bte_i[k*2 +: 2]   = 2'b00;
    endtask

    initial begin
        int cnt, acks, gap, first_err, n_err;
        logic kept, m0_acked, stb_at_err, snooped;

        bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0; bus.wbm_we_i = '0;
        bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0; bus.wbm_cti_i = '0; bus.wbm_bte_i = '0;
        bus.wbs_err_i = 1'b0;
        bus.wbs_rty_i = 1'b0;

        //            cyc      stb      we       grant    scyc  sadr          ack      snp   chkd  dat
        vecs[0]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 32'h0,       4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 32'h100,     4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 32'h100,     4'b0010, 1'b0, 1'b1, 32'h5A5A_5B5A};
        vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, 32'h0,       4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,       4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b0, 32'h0,       4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 32'h2000,    4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 32'h2000,    4'b1000, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 32'h0,       4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,       4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 32'h0,       4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 32'h2000,    4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 32'h2000,    4'b1000, 1'b0, 1'b1, 32'h5A5A_7A5A};
        vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 32'h0,       4'b0000, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,       4'b0000, 1'b0, 1'b0, 32'h0};

        // Reset state
        step(); step(); step();
        check("rst_grant", grant, 0);
        check("rst_scyc", bus.wbs_cyc_o, 0);
        check("rst_sstb", bus.wbs_stb_o, 0);
        check("rst_sadr", bus.wbs_adr_o, 0);
        check("rst_ack", bus.wbm_ack_o, 0);
        check("rst_err", bus.wbm_err_o, 0);
        check("rst_snoop_en", snoop_en, 0);
        check("rst_snoop_adr", snoop_adr, 0);
        rst = 1'b0;

        // Classic read by master 1, then write and read by master 3
        set_master(1, 32'h100, 32'h0, 1'b0, CTI_CLASSIC);
        set_master(3, 32'h2000, 32'hDEAD_BEEF, 1'b0, CTI_CLASSIC);
        for (int i = 0; i < 15; i++) begin
            bus.wbm_cyc_i = vecs[i].cyc;
            bus.wbm_stb_i = vecs[i].stb;
            bus.wbm_we_i  = vecs[i].we;
            #1;
            check($sformatf("v%0d_grant", i), grant, vecs[i].exp_grant);
            check($sformatf("v%0d_scyc", i), bus.wbs_cyc_o, vecs[i].exp_scyc);
            check($sformatf("v%0d_ack", i), bus.wbm_ack_o, vecs[i].exp_ack);
            check($sformatf("v%0d_snoop", i), snoop_en, vecs[i].exp_snoop);
            if (vecs[i].exp_scyc) check($sformatf("v%0d_sadr", i), bus.wbs_adr_o, vecs[i].exp_sadr);
            if (vecs[i].exp_snoop) check($sformatf("v%0d_snoop_adr", i), snoop_adr, 32'h2000);
            if (vecs[i].exp_scyc && vecs[i].we[3]) begin
                check($sformatf("v%0d_sdat", i), bus.wbs_dat_o, 32'hDEAD_BEEF);
                check($sformatf("v%0d_ssel", i), bus.wbs_sel_o, 4'hF);
            end
            if (vecs[i].chk_dat) check($sformatf("v%0d_rdat", i), bus.wbm_dat_o[DW-1:0], vecs[i].exp_dat);
            step();
        end

        // All four masters requesting: rotation 0,1,2,3,0 with an idle cycle between grants
        for (int k = 0; k < NM; k++) set_master(k, 32'h1000 + 32'(k * 16), 32'h0, 1'b0, CTI_CLASSIC);
        bus.wbm_cyc_i = 4'b1111;
        bus.wbm_stb_i = 4'b1111;
        step();
        for (int n = 0; n < 5; n++) begin
            int w;
            w = n % NM;
            check($sformatf("rr%0d_grant", n), grant, 64'(1 << w));
            cnt = 0;
            while (bus.wbm_ack_o == 0 && cnt < 8) begin step(); cnt++; end
            check($sformatf("rr%0d_ack", n), bus.wbm_ack_o, 64'(1 << w));
            step();
            bus.wbm_cyc_i[w] = 1'b0;
            bus.wbm_stb_i[w] = 1'b0;
            #1;
            check($sformatf("rr%0d_release_scyc", n), bus.wbs_cyc_o, 0);
            step();
            check($sformatf("rr%0d_idle", n), grant, 0);
            bus.wbm_cyc_i[w] = 1'b1;
            bus.wbm_stb_i[w] = 1'b1;
            step();
        end
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        step(); step();

        // Master 2 runs an 8-beat INCR burst with a 2-cycle stb gap after beat 4 while master 0 waits
        set_master(0, 32'h1000, 32'h0, 1'b0, CTI_CLASSIC);
        set_master(2, 32'h3000, 32'h0, 1'b0, CTI_INCR);
        bus.wbm_cyc_i = 4'b0101;
        bus.wbm_stb_i = 4'b0101;
        step();
        check("burst_grant", grant, 4'b0100);
        acks = 0; gap = 0; cnt = 0; kept = 1'b1; m0_acked = 1'b0;
        while (acks < 8 && cnt < 60) begin
            if (grant != 4'b0100) kept = 1'b0;
            if (bus.wbm_ack_o[0]) m0_acked = 1'b1;
            if (bus.wbm_ack_o[2]) acks++;
            step();
            cnt++;
            if (acks == 8) begin
                bus.wbm_cyc_i[2] = 1'b0;
                bus.wbm_stb_i[2] = 1'b0;
            end else if (acks == 4 && gap < 2) begin
                bus.wbm_stb_i[2] = 1'b0;
                gap++;
            end else begin
                bus.wbm_stb_i[2] = 1'b1;
                bus.wbm_cti_i[2*3 +: 3] = (acks == 7) ? CTI_EOB : CTI_INCR;
            end
        end
        check("burst_beats", acks, 8);
        check("burst_grant_kept", kept, 1'b1);
        check("burst_no_m0_ack", m0_acked, 1'b0);
        #1;
        check("burst_release_scyc", bus.wbs_cyc_o, 0);
        step();
        check("burst_idle", grant, 0);
        step();
        check("burst_next_grant", grant, 4'b0001);
        cnt = 0;
        while (bus.wbm_ack_o == 0 && cnt < 8) begin step(); cnt++; end
        check("burst_m0_ack", bus.wbm_ack_o, 4'b0001);
        step();
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        step(); step();

        // Watchdog: silent slave, master 1 writes and is terminated on the 16th stb cycle
        mute = 1'b1;
        set_master(1, 32'h100, 32'h1234_5678, 1'b1, CTI_CLASSIC);
        bus.wbm_cyc_i[1] = 1'b1;
        bus.wbm_stb_i[1] = 1'b1;
        step();
        first_err = 0; n_err = 0; stb_at_err = 1'b1; snooped = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.wbm_err_o[1]) begin
                n_err++;
                if (first_err == 0) first_err = i;
                stb_at_err = bus.wbs_stb_o;
            end
            if (snoop_en) snooped = 1'b1;
            step();
        end
        check("wd_first_err_cycle", first_err, TO);
        check("wd_err_count", n_err, 1);
        check("wd_stb_at_err", stb_at_err, 1'b0);
        check("wd_no_snoop", snooped, 1'b0);
        check("wd_grant_held", grant, 4'b0010);
        bus.wbm_cyc_i[1] = 1'b0;
        bus.wbm_stb_i[1] = 1'b0;
        step();
        check("wd_idle", grant, 0);
        mute = 1'b0;
        set_master(1, 32'h100, 32'h0, 1'b0, CTI_CLASSIC);
        bus.wbm_cyc_i[1] = 1'b1;
        bus.wbm_stb_i[1] = 1'b1;
        step();
        check("wd_regrant", grant, 4'b0010);
        cnt = 0;
        while (bus.wbm_ack_o == 0 && cnt < 8) begin step(); cnt++; end
        check("wd_next_ack", bus.wbm_ack_o, 4'b0010);
        check("wd_next_err", bus.wbm_err_o, 0);
        step();
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        step(); step();

        // Reset in the middle of a master 2 burst
        set_master(2, 32'h3000, 32'h0, 1'b0, CTI_INCR);
        bus.wbm_cyc_i[2] = 1'b1;
        bus.wbm_stb_i[2] = 1'b1;
        step();
        cnt = 0;
        while (bus.wbm_ack_o == 0 && cnt < 8) begin step(); cnt++; end
        check("mid_ack", bus.wbm_ack_o, 4'b0100);
        step();
        rst = 1'b1;
        step();
        check("mrst_grant", grant, 0);
        check("mrst_scyc", bus.wbs_cyc_o, 0);
        check("mrst_sstb", bus.wbs_stb_o, 0);
        check("mrst_sadr", bus.wbs_adr_o, 0);
        check("mrst_ack", bus.wbm_ack_o, 0);
        check("mrst_snoop", snoop_en, 0);
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        step();
        rst = 1'b0;
        set_master(0, 32'h1000, 32'h0, 1'b0, CTI_CLASSIC);
        set_master(3, 32'h2000, 32'h0, 1'b0, CTI_CLASSIC);
        bus.wbm_cyc_i = 4'b1001;
        bus.wbm_stb_i = 4'b1001;
        step();
        check("post_rst_grant", grant, 4'b0001);
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Round-robin Wishbone B3 arbiter sharing the single main-RAM slave port between the per-core instruction and data masters (default 4: or1k0 i/d, or1k1 i/d).
- Sits between the masters and ram_wb_b3.
- Holds grant for a whole cycle or burst.
- Provides a per-request watchdog that terminates hung cycles with err.
- Generates the write-snoop strobe that all cores consume for coherence.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- AW, 32, address width
- DW, 32, data width (SEL width = DW/8)
- TIMEOUT, 1024, cycles without ack/err/rty before forced err; 0 disables watchdog

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- wbm_adr_i  in  NUM_MASTERS*AW  master addresses, master k at [k*AW +: AW]
- wbm_dat_i  in  NUM_MASTERS*DW  master write data
- wbm_sel_i  in  NUM_MASTERS*DW/8  byte selects
- wbm_we_i  in  NUM_MASTERS  write enables
- wbm_cyc_i  in  NUM_MASTERS  cycle requests
- wbm_stb_i  in  NUM_MASTERS  strobes
- wbm_cti_i  in  NUM_MASTERS*3  cycle type
- wbm_bte_i  in  NUM_MASTERS*2  burst type
- wbm_dat_o  out  NUM_MASTERS*DW  read data (slave data broadcast)
- wbm_ack_o  out  NUM_MASTERS  ack, granted master only
- wbm_err_o  out  NUM_MASTERS  err, granted master only
- wbm_rty_o  out  NUM_MASTERS  rty, granted master only
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  AW/DW/DW/8/1/1/1/3/2  slave-side request
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  DW/1/1/1  slave response
- snoop_adr_o  out  AW  address of completed write
- snoop_en_o  out  1  write-completion pulse
- grant_o  out  NUM_MASTERS  one-hot current grant (debug/perf)

Behaviour:
- Clock/reset: one clock wb_clk_i; wb_rst_i synchronous, active-high.
- Reset values: state=IDLE, grant_o=0, last-served pointer=NUM_MASTERS-1, watchdog=0. All wbs_* outputs 0; wbm_ack/err/rty_o 0; snoop_en_o 0; snoop_adr_o 0.
- Reset mid-cycle: grant dropped the next edge with no response to the master. The master must also be reset by the same wb_rst_i.
- State IDLE:
  - If any wbm_cyc_i is set, register grant to the first requester searching from (last+1) mod NUM_MASTERS upward with wrap.
  - Go to BUSY and update last := winner.
  - Arbitration costs exactly 1 cycle: slave sees cyc on the cycle after the master raises cyc.
- State BUSY:
  - Slave outputs are a combinational mux of the granted master's inputs.
  - Slave ack/err/rty are routed to the granted master; other masters see 0.
  - wbm_dat_o is slave data replicated to all masters.
- Release: on the cycle the granted master's cyc_i is low, go to IDLE. The slave cyc is low in that same cycle (combinational). No re-arbitration in the release cycle; an idle cycle always separates grants.
- Burst handling:
  - Grant is never removed while the granted cyc stays high, including stb low gaps inside bursts and cti=111 end.
  - A master that keeps cyc high after cti=111 keeps the grant.
- Watchdog:
  - Counter clears on grant, on any slave ack/err/rty, and when stb is low.
  - Increments while granted stb is high with no response.
  - On reaching TIMEOUT: assert wbm_err_o to the granted master for exactly 1 cycle, suppress slave cyc/stb that cycle, then wait for the master to drop cyc.
  - A slave ack arriving in the same cycle as the timeout wins; no err is issued.
- Snoop:
  - snoop_en_o = wbs_cyc_o & wbs_stb_o & wbs_we_o & wbs_ack_i, combinational, same cycle as the ack.
  - snoop_adr_o = wbs_adr_o (combinational).
  - Watchdog err never produces a snoop.
- Simultaneous requests: a single winner per rotation. With N masters continuously requesting, each is granted once every N grants (starvation-free).
- Invariant: grant_o is one-hot or zero at all times.

Decomposition:
- Shared package/header wb_arb_defs:
  - CTI constants: CLASSIC=000, CONST=001, INCR=010, EOB=111.
  - Arbiter state encoding: IDLE, BUSY.
- Sub-module rr_pick: combinational priority rotator.
  - Inputs: request vector, last pointer.
  - Outputs: one-hot winner and its index.
  - Reused by a future IPI/peripheral arbiter.

Test Plan:
- Single master 1, classic read at 0x100: cyc rises at t -> wbs_cyc_o at t+1, grant_o=0010, ack returned to master 1 only; cyc drop -> grant_o=0 next cycle.
- All 4 masters hold cyc continuously, with the slave acking each cycle after 1 wait state -> grant order 0,1,2,3,0, each grant separated by one idle cycle.
- Master 2 runs an 8-beat INCR burst (bte=00) with a 2-cycle stb gap at beat 4 while master 0 requests -> master 2 keeps grant through all 8 acks; master 0 granted only after master 2 drops cyc.
- Master 3 writes 0xDEADBEEF to 0x2000, sel=1111 -> snoop_en_o pulses 1 cycle coincident with ack, snoop_adr_o=0x2000; a read to the same address gives no pulse.
- TIMEOUT=16, slave never acks master 1 -> wbm_err_o[1] high exactly at the 16th stb cycle, slave stb low that cycle, no snoop; master drops cyc -> IDLE; next request served normally.
- wb_rst_i asserted mid-burst -> all outputs 0 on the next edge; after release, the first arbitration starts search at master 0.
